// File: rtl/excess3_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// excess3_to_bcd_serial
//
// Serial Excess-3 to BCD decoder for the receive side of the serial digit link.
// Each digit arrives as 4 bits, LSB first. The BCD bit is produced in the same
// cycle as a Mealy output: the code minus 3, computed with a serial borrow.
// When a digit completes, the decoded value is presented in parallel and
// invalid codes are flagged. Valid and invalid digits are counted.
//
// Handshake: a bit is transferred on every rising clock edge where x_valid=1.
// There is no back-pressure. z/z_valid qualify the same cycle's bit. x_sof
// with x_valid forces the current bit to be bit 0 of a new digit.
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous, active-high
//   x           - serial Excess-3 bit (LSB first), sampled when x_valid=1
//   x_valid     - bit strobe; all state holds while low
//   x_sof       - start-of-digit marker, qualified by x_valid
//   z           - serial BCD bit (combinational, 0 when x_valid=0)
//   z_valid     - equals x_valid
//   bcd_q       - last valid decoded digit
//   digit_valid - one-cycle pulse after each completed digit
//   err         - one-cycle pulse alongside digit_valid for an invalid code
//   digit_cnt   - valid digits decoded, wraps
//   err_cnt     - invalid digits seen, saturates
// -----------------------------------------------------------------------------
module excess3_to_bcd_serial #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             x_sof,
  output logic             z,
  output logic             z_valid,
  output logic [3:0]       bcd_q,
  output logic             digit_valid,
  output logic             err,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  logic [1:0] bit_idx;
  logic       borrow;
  logic [2:0] sr;
  logic [2:0] zs;

  logic [1:0] idx;
  logic       b_eff;
  logic       borrow_nxt;
  logic [3:0] code;
  logic       code_ok;
  logic       done;

  always_comb begin
    idx        = x_sof ? 2'd0 : bit_idx;
    // Bit 0 never consumes a borrow left behind by an abandoned digit.
    b_eff      = (idx != 2'd0) && borrow;
    z          = 1'b0;
    borrow_nxt = borrow;
    z_valid    = x_valid;
    code       = {x, sr};
    code_ok    = (code >= 4'd3) && (code <= 4'd12);
    done       = x_valid && (idx == 2'd3);
    if (x_valid) begin
      // Subtrahend 3 = 4'b0011: bits 0 and 1 subtract 1, bits 2 and 3 only
      // propagate the borrow.
      case (idx)
        2'd0: begin
          z          = ~x;
          borrow_nxt = ~x;
        end
        2'd1: begin
          if (b_eff) begin
            z          = x;
            borrow_nxt = 1'b1;
          end else begin
            z          = ~x;
            borrow_nxt = ~x;
          end
        end
        2'd2: begin
          z          = x ^ b_eff;
          borrow_nxt = ~x & b_eff;
        end
        default: begin
          z          = x ^ b_eff;
          borrow_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx     <= 2'd0;
      borrow      <= 1'b0;
      sr          <= 3'b000;
      zs          <= 3'b000;
      bcd_q       <= 4'd0;
      digit_valid <= 1'b0;
      err         <= 1'b0;
      digit_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      digit_valid <= done;
      err         <= done && !code_ok;
      if (x_valid) begin
        bit_idx <= idx + 2'd1;
        borrow  <= borrow_nxt;
        case (idx)
          2'd0: begin
            sr[0] <= x;
            zs[0] <= z;
          end
          2'd1: begin
            sr[1] <= x;
            zs[1] <= z;
          end
          2'd2: begin
            sr[2] <= x;
            zs[2] <= z;
          end
          default: ;
        endcase
      end
      if (done && code_ok) begin
        bcd_q     <= {z, zs};
        digit_cnt <= digit_cnt + 1'b1;
      end
      if (done && !code_ok && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// tb_excess3_to_bcd_serial
//
// Bench for excess3_to_bcd_serial. A behavioural model keeps the digit
// arithmetically (accumulated code value, code-3 mod 16) and is compared with
// the DUT on every falling edge. Directed scenarios pin the model with
// hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_excess3_to_bcd_serial;

  logic       clock;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       x_sof;
  logic       z;
  logic       z_valid;
  logic [3:0] bcd_q;
  logic       digit_valid;
  logic       err;
  logic [7:0] digit_cnt;
  logic [3:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  excess3_to_bcd_serial #(.CNT_W(8), .ERR_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .x_sof       (x_sof),
    .z           (z),
    .z_valid     (z_valid),
    .bcd_q       (bcd_q),
    .digit_valid (digit_valid),
    .err         (err),
    .digit_cnt   (digit_cnt),
    .err_cnt     (err_cnt)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- checker
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit         m_live = 1'b0;
  int         m_cnt;          // bits received in the current digit
  int         m_acc;          // code value accumulated so far
  logic [3:0] m_bcd;
  logic       m_dv;
  logic       m_err;
  logic [7:0] m_dcnt;
  logic [3:0] m_ecnt;
  logic [4:0] exp_q[$];       // {err, bcd_q} expected at each completion pulse
  logic       obs_z[$];       // z seen on valid cycles, for literal pinning

  always @(negedge clock) begin
    int         idx;
    int         val;
    int         code;
    logic       exp_z;
    logic [4:0] e;
    if (m_live) begin
      chk("digit_valid", digit_valid, m_dv);
      chk("err", err, m_err);
      chk("bcd_q", bcd_q, m_bcd);
      chk("digit_cnt", digit_cnt, m_dcnt);
      chk("err_cnt", err_cnt, m_ecnt);
      if (digit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pulse_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_err_bcd", {err, bcd_q}, e);
        end
      end
      chk("z_valid", z_valid, x_valid);
      if (x_valid) begin
        idx   = x_sof ? 0 : m_cnt;
        val   = (idx == 0 ? 0 : m_acc) | (int'(x) << idx);
        exp_z = ((val + 16 - 3) >> idx) & 1;
        chk("z", z, exp_z);
        obs_z.push_back(z);
      end else begin
        chk("z_idle", z, 0);
      end
    end
    // advance the model across the coming rising edge
    if (reset) begin
      m_live = 1'b1;
      m_cnt  = 0;
      m_acc  = 0;
      m_bcd  = 4'd0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
      m_dcnt = 8'd0;
      m_ecnt = 4'd0;
      exp_q.delete();
    end else if (m_live) begin
      m_dv  = 1'b0;
      m_err = 1'b0;
      if (x_valid) begin
        idx = x_sof ? 0 : m_cnt;
        if (idx == 0) m_acc = 0;
        m_acc = m_acc | (int'(x) << idx);
        if (idx == 3) begin
          code = m_acc;
          m_dv = 1'b1;
          if (code >= 3 && code <= 12) begin
            m_bcd  = 4'(code - 3);
            m_dcnt = m_dcnt + 8'd1;
          end else begin
            m_err = 1'b1;
            if (m_ecnt != 4'd15) m_ecnt = m_ecnt + 4'd1;
          end
          exp_q.push_back({m_err, m_bcd});
          m_cnt = 0;
        end else begin
          m_cnt = idx + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    reset   = 1'b1;
    x_valid = 1'b0;
    x_sof   = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Present one bit; returns just after the edge that samples it.
  task automatic send_bit(input logic b, input logic sof);
    x       = b;
    x_sof   = sof;
    x_valid = 1'b1;
    @(posedge clock); #1;
    x_valid = 1'b0;
    x_sof   = 1'b0;
  endtask

  // Idle cycles with random x/x_sof that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      x       = 1'($urandom_range(0, 1));
      x_sof   = 1'($urandom_range(0, 1));
      x_valid = 1'b0;
      @(posedge clock); #1;
    end
    x_sof = 1'b0;
  endtask

  task automatic send_code(input int code, input logic sof_first, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      if (gap_max > 0) idle($urandom_range(1, gap_max));
      send_bit(1'((code >> i) & 1), (i == 0) ? sof_first : 1'b0);
    end
  endtask

  function automatic int obs_nibble();
    int v = 0;
    for (int i = 0; i < obs_z.size(); i++) v = v | (int'(obs_z[i]) << i);
    return v;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int code;
    int nab;
    logic sof;
    reset   = 1'b1;
    x       = 1'b0;
    x_valid = 1'b0;
    x_sof   = 1'b0;
    do_reset();

    // reset state
    chk("rst_bcd_q", bcd_q, 0);
    chk("rst_digit_valid", digit_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_digit_cnt", digit_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // digit 5 from code 1000
    obs_z.delete();
    send_code(8, 1'b0, 0);
    chk("d5_z_count", obs_z.size(), 4);
    chk("d5_z_bits", obs_nibble(), 5);
    chk("d5_digit_valid", digit_valid, 1);
    chk("d5_err", err, 0);
    chk("d5_bcd_q", bcd_q, 5);
    chk("d5_digit_cnt", digit_cnt, 1);

    // codes 0011 and 1100 back to back
    do_reset();
    obs_z.delete();
    send_code(3, 1'b0, 0);
    chk("b2b_z_first", obs_nibble(), 0);
    chk("b2b_bcd_first", bcd_q, 0);
    chk("b2b_dv_first", digit_valid, 1);
    obs_z.delete();
    send_code(12, 1'b0, 0);
    chk("b2b_z_second", obs_nibble(), 9);
    chk("b2b_bcd_second", bcd_q, 9);
    chk("b2b_dv_second", digit_valid, 1);
    chk("b2b_digit_cnt", digit_cnt, 2);

    // invalid codes after a valid 5
    do_reset();
    send_code(8, 1'b1, 0);
    obs_z.delete();
    send_code(15, 1'b0, 0);
    chk("inv15_z_bits", obs_nibble(), 12);
    chk("inv15_err", err, 1);
    chk("inv15_dv", digit_valid, 1);
    chk("inv15_bcd_hold", bcd_q, 5);
    send_code(1, 1'b0, 0);
    chk("inv1_err", err, 1);
    chk("inv1_bcd_hold", bcd_q, 5);
    chk("inv_err_cnt", err_cnt, 2);
    chk("inv_digit_cnt", digit_cnt, 1);
    @(posedge clock); #1;
    chk("inv_err_cleared", err, 0);

    // digit 5 with gaps between bits
    do_reset();
    obs_z.delete();
    send_code(8, 1'b0, 5);
    chk("gap_z_bits", obs_nibble(), 5);
    chk("gap_bcd_q", bcd_q, 5);
    chk("gap_digit_cnt", digit_cnt, 1);

    // abandon two bits with x_sof on a fresh 1000
    do_reset();
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("sof_no_pulse", digit_valid, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("sof_dv", digit_valid, 1);
    chk("sof_bcd_q", bcd_q, 5);
    chk("sof_digit_cnt", digit_cnt, 1);
    chk("sof_err_cnt", err_cnt, 0);

    // reset mid-digit
    do_reset();
    send_code(8, 1'b0, 0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();
    chk("midrst_digit_cnt", digit_cnt, 0);
    chk("midrst_bcd_q", bcd_q, 0);
    send_code(12, 1'b0, 0);
    chk("midrst_bcd_final", bcd_q, 9);
    chk("midrst_cnt_final", digit_cnt, 1);

    // err_cnt saturation
    do_reset();
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0: code = 0;
        1: code = 1;
        2: code = 2;
        3: code = 13;
        4: code = 14;
        default: code = 15;
      endcase
      send_code(code, 1'b0, 0);
    end
    chk("sat_err_cnt", err_cnt, 15);
    chk("sat_digit_cnt", digit_cnt, 0);

    // randomized traffic, enough valid digits to wrap digit_cnt
    do_reset();
    for (int d = 0; d < 450; d++) begin
      sof = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        nab = $urandom_range(1, 3);
        for (int i = 0; i < nab; i++)
          send_bit(1'($urandom_range(0, 1)), (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        sof = 1'b1;
      end
      code = $urandom_range(0, 15);
      send_code(code, sof, ($urandom_range(0, 2) == 0) ? 5 : 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
